// File: rtl/pc_ras_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_if
// Description : Control/status bundle between a fetch unit and pc_ras.
// Revision    : 1.0
// ============================================================================
interface pc_ras_if #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
);
    logic                         stall;
    logic                         branch_en;
    logic                         call_en;
    logic                         ret_en;
    logic [ADDR_W-1:0]            target;
    logic [ADDR_W-1:0]            pc;
    logic [$clog2(RAS_DEPTH):0]   ras_count;
    logic                         ras_empty;
    logic                         ras_full;
    logic                         ras_ovf;
    logic                         ras_udf;

    modport master (
        output stall, branch_en, call_en, ret_en, target,
        input  pc, ras_count, ras_empty, ras_full, ras_ovf, ras_udf
    );

    modport slave (
        input  stall, branch_en, call_en, ret_en, target,
        output pc, ras_count, ras_empty, ras_full, ras_ovf, ras_udf
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Program counter with branch/call/return and a return-address stack.
// Revision    : 1.0
// ============================================================================
module pc_ras #(
    parameter int                ADDR_W     = 8,
    parameter int                STEP       = 1,
    parameter int                RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  wire          clk,
    input  wire          reset,
    pc_ras_if.slave      bus
);

    localparam int                PTR_W   = $clog2(RAS_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  c_DEPTH = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  c_ONE   = CNT_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_udf;
    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];

    logic [ADDR_W-1:0] w_pc_inc;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic [PTR_W-1:0]  w_top_idx;
    logic [PTR_W-1:0]  w_push_idx;
    logic              w_empty;
    logic              w_full;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_udf_set;

    assign w_pc_inc   = r_pc + c_STEP;
    assign w_cnt_dec  = r_count - c_ONE;
    assign w_top_idx  = w_cnt_dec[PTR_W-1:0];
    assign w_push_idx = r_count[PTR_W-1:0];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);

    // Priority among non-stall controls: return, then call, then branch.
    always_comb begin
        w_pc_nxt  = w_pc_inc;
        w_cnt_nxt = r_count;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (bus.ret_en) begin
            if (w_empty) begin
                w_udf_set = 1'b1;
            end else begin
                w_pc_nxt  = r_stack[w_top_idx];
                w_cnt_nxt = w_cnt_dec;
            end
        end else if (bus.call_en) begin
            w_pc_nxt = bus.target;
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_cnt_nxt = r_count + c_ONE;
            end
        end else if (bus.branch_en) begin
            w_pc_nxt = bus.target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= RESET_ADDR;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (!bus.stall) begin
            r_pc    <= w_pc_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_udf   <= r_udf | w_udf_set;
        end
    end

    // Entries need no reset: they are unreachable while the count is zero.
    always_ff @(posedge clk) begin
        if (reset && !bus.stall && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.ras_count = r_count;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
    assign bus.ras_ovf   = r_ovf;
    assign bus.ras_udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ras
// Description : Directed vector table plus randomized run against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_pc_ras;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pc_ras_if #(.ADDR_W(8), .RAS_DEPTH(4)) bus ();

    pc_ras #(
        .ADDR_W    (8),
        .STEP      (1),
        .RAS_DEPTH (4),
        .RESET_ADDR(8'h00)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       stall;
        logic       br;
        logic       call;
        logic       ret;
        logic [7:0] target;
        logic [7:0] pc;
        int         cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_ovf;
    logic       m_udf;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic rst_n, input logic st, input logic br,
                         input logic call, input logic ret, input logic [7:0] tgt);
        reset         = rst_n;
        bus.stall     = st;
        bus.branch_en = br;
        bus.call_en   = call;
        bus.ret_en    = ret;
        bus.target    = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc, input int cnt,
                               input logic ovf, input logic udf);
        check({tag, ".pc"},    int'(bus.pc),        int'(pc));
        check({tag, ".cnt"},   int'(bus.ras_count), cnt);
        check({tag, ".empty"}, int'(bus.ras_empty), int'(cnt == 0));
        check({tag, ".full"},  int'(bus.ras_full),  int'(cnt == 4));
        check({tag, ".ovf"},   int'(bus.ras_ovf),   int'(ovf));
        check({tag, ".udf"},   int'(bus.ras_udf),   int'(udf));
    endtask

    task automatic model_step(input logic rst_n, input logic st, input logic br,
                              input logic call, input logic ret, input logic [7:0] tgt);
        if (!rst_n) begin
            m_pc = 8'h00;
            m_stack.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (st) begin
            // hold everything
        end else if (ret) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else begin
                m_pc  = 8'(m_pc + 8'd1);
                m_udf = 1'b1;
            end
        end else if (call) begin
            if (m_stack.size() < 4) m_stack.push_back(8'(m_pc + 8'd1));
            else                    m_ovf = 1'b1;
            m_pc = tgt;
        end else if (br) begin
            m_pc = tgt;
        end else begin
            m_pc = 8'(m_pc + 8'd1);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.stall = 1'b0; bus.branch_en = 1'b0; bus.call_en = 1'b0;
        bus.ret_en = 1'b0; bus.target = 8'h00;

        //            rst   st    br    call  ret   tgt    pc     cnt ovf   udf
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h20, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h30, 2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h50, 4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 8'h60, 4, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h41, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h31, 2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h21, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h06, 0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 8'h06, 0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h78, 8'h06, 0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90, 8'h90, 2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA0, 8'h00, 0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h01, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 8'h44, 1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h02, 0, 1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].call, tbl[i].ret, tbl[i].target);
            check_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cnt, tbl[i].ovf, tbl[i].udf);
        end

        // Hand sequence: a pop then push reuses the freed slot with the new address.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0);   // push 01
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hD0);   // push C1
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);   // pop  -> C1
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0);   // push C2 over freed slot
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_state("lifo_reuse_a", 8'hC2, 1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_state("lifo_reuse_b", 8'h01, 0, 1'b0, 1'b0);

        // Randomized run against the queue model.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 600; c++) begin
            logic       r_n, st, br, ca, rt;
            logic [7:0] tg;
            r_n = ($urandom_range(0, 39) != 0);
            st  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 3) == 0);
            ca  = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            tg  = 8'($urandom);
            apply(r_n, st, br, ca, rt, tg);
            model_step(r_n, st, br, ca, rt, tg);
            check_state($sformatf("rnd%0d", c), m_pc, m_stack.size(), m_ovf, m_udf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
